// File: rtl/supernova_pkg.sv
`default_nettype none
// ============================================================================
// Module   : supernova_pkg
// Purpose  : Shared Supernova core types and constants used by the FP issue
//            queue: data/tag widths, FP operation encodings, the
//            reservation-station entry, and the FP issue-queue slot.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package supernova_pkg;

  localparam int XLEN          = 64;
  localparam int FPR_TAG_WIDTH = 6;
  localparam int ROB_IDX_WIDTH = 6;
  localparam int FP_IQ_DEPTH   = 8;

  typedef enum logic [3:0] {
    FP_OP_ADD   = 4'd0,
    FP_OP_SUB   = 4'd1,
    FP_OP_MUL   = 4'd2,
    FP_OP_DIV   = 4'd3,
    FP_OP_SQRT  = 4'd4,
    FP_OP_FMADD = 4'd5,
    FP_OP_CVT   = 4'd6,
    FP_OP_CMP   = 4'd7
  } fp_op_e;

  typedef enum logic {
    FP_FMT_S = 1'b0,
    FP_FMT_D = 1'b1
  } fp_fmt_e;

  // Renamed F/D instruction as carried from dispatch to the FPU.
  typedef struct packed {
    fp_op_e                   op;
    fp_fmt_e                  fmt;
    logic [2:0]               rm;
    logic [XLEN-1:0]          src1_data;
    logic [XLEN-1:0]          src2_data;
    logic [FPR_TAG_WIDTH-1:0] rd_phys_tag;
    logic [ROB_IDX_WIDTH-1:0] rob_idx;
  } rs_entry_t;

  // One reservation-station slot: entry plus per-operand wakeup state.
  typedef struct packed {
    logic                     valid;
    rs_entry_t                entry;
    logic                     src1_rdy;
    logic                     src2_rdy;
    logic [FPR_TAG_WIDTH-1:0] src1_tag;
    logic [FPR_TAG_WIDTH-1:0] src2_tag;
  } fp_iq_slot_t;

  // True when a still-waiting operand is produced by the current writeback.
  function automatic logic cdb_hit(
    input logic                     rdy,
    input logic                     cdb_valid,
    input logic [FPR_TAG_WIDTH-1:0] tag,
    input logic [FPR_TAG_WIDTH-1:0] cdb_tag
  );
    return !rdy && cdb_valid && (tag == cdb_tag);
  endfunction

endpackage : supernova_pkg
`default_nettype wire

// File: rtl/supernova_fp_iq_select.sv
`default_nettype none
// ============================================================================
// Module   : supernova_fp_iq_select
// Purpose  : Combinational oldest-ready priority encoder. Slot 0 is the
//            oldest, so the lowest set request bit wins.
// Ports    : i_req   - per-slot "valid and both operands ready"
//            o_idx   - index of the lowest set bit (0 when none)
//            o_found - at least one request bit is set
// Revision : 1.0 - initial release
// ============================================================================
module supernova_fp_iq_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]         i_req,
  output logic [$clog2(DEPTH)-1:0] o_idx,
  output logic                     o_found
);

  localparam int IW = $clog2(DEPTH);

  // Scan from the youngest slot downward so the oldest request is the last
  // (winning) assignment.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = IW'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule : supernova_fp_iq_select
`default_nettype wire

// File: rtl/supernova_fp_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : supernova_fp_issue_queue
// Purpose  : FP reservation station. Buffers renamed F/D instructions in a
//            collapsing age-ordered queue (slot 0 oldest, valid slots
//            contiguous), wakes operands from the FP writeback bus, and
//            issues the oldest fully-ready entry to the FPU over valid/ready.
// Ports    : clk, rst_n (async, active low)
//            flush_in                       - drop all entries
//            disp_*_in / disp_ready_out     - dispatch handshake + operand state
//            cdb_valid_in/tag_in/data_in    - FP writeback snoop
//            iss_valid_out/entry_out, iss_ready_in - issue handshake to FPU
//            count_out                      - occupied entries
//            perf_stall_cnt_out             - only with SUPERNOVA_FP_IQ_PERF_EN:
//                                             saturating count of stalled
//                                             issue cycles (valid && !ready)
// Config   : `define SUPERNOVA_FP_IQ_PERF_EN to add the stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module supernova_fp_issue_queue
  import supernova_pkg::*;
#(
  parameter int DEPTH = FP_IQ_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_in,
  input  logic                          disp_valid_in,
  input  rs_entry_t                     disp_entry_in,
  input  logic                          disp_src1_rdy_in,
  input  logic                          disp_src2_rdy_in,
  input  logic [FPR_TAG_WIDTH-1:0]      disp_src1_tag_in,
  input  logic [FPR_TAG_WIDTH-1:0]      disp_src2_tag_in,
  output logic                          disp_ready_out,
  input  logic                          cdb_valid_in,
  input  logic [FPR_TAG_WIDTH-1:0]      cdb_tag_in,
  input  logic [XLEN-1:0]               cdb_data_in,
  output logic                          iss_valid_out,
  output rs_entry_t                     iss_entry_out,
  input  logic                          iss_ready_in,
  output logic [$clog2(DEPTH):0]        count_out
`ifdef SUPERNOVA_FP_IQ_PERF_EN
  ,
  output logic [31:0]                   perf_stall_cnt_out
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  fp_iq_slot_t      r_slot  [DEPTH];
  logic [CW-1:0]    r_count;

  fp_iq_slot_t      w_ext   [DEPTH+1];
  fp_iq_slot_t      w_nxt   [DEPTH];
  fp_iq_slot_t      w_new;
  logic [DEPTH-1:0] w_req;
  logic [IW-1:0]    w_sel_idx;
  logic             w_sel_found;
  logic             w_disp;
  logic             w_issue;
  logic [CW-1:0]    w_wpos;
  logic [CW-1:0]    w_count_nxt;

  // --------------------------------------------------------------------------
  // Select: registered ready bits only, so a wakeup becomes visible next cycle.
  // --------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_req
      assign w_req[g] = r_slot[g].valid & r_slot[g].src1_rdy & r_slot[g].src2_rdy;
    end
  endgenerate

  supernova_fp_iq_select #(
    .DEPTH (DEPTH)
  ) u_select (
    .i_req   (w_req),
    .o_idx   (w_sel_idx),
    .o_found (w_sel_found)
  );

  assign iss_valid_out  = w_sel_found & ~flush_in;
  assign iss_entry_out  = r_slot[w_sel_idx].entry;
  assign w_issue        = iss_valid_out & iss_ready_in;

  // No credit for a same-cycle issue: a full queue refuses dispatch.
  assign disp_ready_out = (r_count < CW'(DEPTH));
  assign w_disp         = disp_valid_in & disp_ready_out;
  assign count_out      = r_count;

  // With an issue the occupied region collapses by one before the write.
  assign w_wpos         = w_issue ? (r_count - CW'(1)) : r_count;

  // --------------------------------------------------------------------------
  // Incoming slot with dispatch-time wakeup so a writeback in the acceptance
  // cycle is not lost.
  // --------------------------------------------------------------------------
  always_comb begin
    w_new.valid    = 1'b1;
    w_new.entry    = disp_entry_in;
    w_new.src1_rdy = disp_src1_rdy_in;
    w_new.src2_rdy = disp_src2_rdy_in;
    w_new.src1_tag = disp_src1_tag_in;
    w_new.src2_tag = disp_src2_tag_in;
    if (cdb_hit(disp_src1_rdy_in, cdb_valid_in, disp_src1_tag_in, cdb_tag_in)) begin
      w_new.src1_rdy        = 1'b1;
      w_new.entry.src1_data = cdb_data_in;
    end
    if (cdb_hit(disp_src2_rdy_in, cdb_valid_in, disp_src2_tag_in, cdb_tag_in)) begin
      w_new.src2_rdy        = 1'b1;
      w_new.entry.src2_data = cdb_data_in;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state of the slot array: collapse on issue, then wake the shifted
  // copies, then insert the dispatch, then let flush clear every valid bit.
  // The extra top element of w_ext is an empty slot shifted into the tail.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_ext[i] = r_slot[i];
    end
    w_ext[DEPTH] = '0;

    for (int i = 0; i < DEPTH; i++) begin
      if (w_issue && (i >= int'(w_sel_idx))) begin
        w_nxt[i] = w_ext[i+1];
      end else begin
        w_nxt[i] = w_ext[i];
      end

      if (w_nxt[i].valid &&
          cdb_hit(w_nxt[i].src1_rdy, cdb_valid_in, w_nxt[i].src1_tag, cdb_tag_in)) begin
        w_nxt[i].src1_rdy        = 1'b1;
        w_nxt[i].entry.src1_data = cdb_data_in;
      end
      if (w_nxt[i].valid &&
          cdb_hit(w_nxt[i].src2_rdy, cdb_valid_in, w_nxt[i].src2_tag, cdb_tag_in)) begin
        w_nxt[i].src2_rdy        = 1'b1;
        w_nxt[i].entry.src2_data = cdb_data_in;
      end

      if (w_disp && (CW'(i) == w_wpos)) begin
        w_nxt[i] = w_new;
      end

      if (flush_in) begin
        w_nxt[i].valid = 1'b0;
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (flush_in) begin
      w_count_nxt = '0;
    end else if (w_disp && !w_issue) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_disp && w_issue) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slot[i] <= '0;
      end
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slot[i] <= w_nxt[i];
      end
      r_count <= w_count_nxt;
    end
  end

`ifdef SUPERNOVA_FP_IQ_PERF_EN
  // Saturating stall counter; deliberately not cleared by flush.
  logic [31:0] r_perf_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall_cnt <= '0;
    end else if (iss_valid_out && !iss_ready_in && (r_perf_stall_cnt != '1)) begin
      r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt_out = r_perf_stall_cnt;
`endif

endmodule : supernova_fp_issue_queue
`default_nettype wire

// File: tb/tb_supernova_fp_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_supernova_fp_issue_queue
// Purpose  : Self-checking bench for supernova_fp_issue_queue. A queue-based
//            reference model predicts every issue; predicted entries go into
//            a scoreboard that a negedge monitor drains on each handshake.
//            Directed scenarios are followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_supernova_fp_issue_queue;
  import supernova_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     flush_in;
  logic                     disp_valid_in;
  rs_entry_t                disp_entry_in;
  logic                     disp_src1_rdy_in;
  logic                     disp_src2_rdy_in;
  logic [FPR_TAG_WIDTH-1:0] disp_src1_tag_in;
  logic [FPR_TAG_WIDTH-1:0] disp_src2_tag_in;
  logic                     disp_ready_out;
  logic                     cdb_valid_in;
  logic [FPR_TAG_WIDTH-1:0] cdb_tag_in;
  logic [XLEN-1:0]          cdb_data_in;
  logic                     iss_valid_out;
  rs_entry_t                iss_entry_out;
  logic                     iss_ready_in;
  logic [CW-1:0]            count_out;
`ifdef SUPERNOVA_FP_IQ_PERF_EN
  logic [31:0]              perf_stall_cnt_out;
  longint                   m_perf;
`endif

  supernova_fp_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_in         (flush_in),
    .disp_valid_in    (disp_valid_in),
    .disp_entry_in    (disp_entry_in),
    .disp_src1_rdy_in (disp_src1_rdy_in),
    .disp_src2_rdy_in (disp_src2_rdy_in),
    .disp_src1_tag_in (disp_src1_tag_in),
    .disp_src2_tag_in (disp_src2_tag_in),
    .disp_ready_out   (disp_ready_out),
    .cdb_valid_in     (cdb_valid_in),
    .cdb_tag_in       (cdb_tag_in),
    .cdb_data_in      (cdb_data_in),
    .iss_valid_out    (iss_valid_out),
    .iss_entry_out    (iss_entry_out),
    .iss_ready_in     (iss_ready_in),
    .count_out        (count_out)
`ifdef SUPERNOVA_FP_IQ_PERF_EN
    ,
    .perf_stall_cnt_out (perf_stall_cnt_out)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: age-ordered list of waiting instructions.
  typedef struct {
    rs_entry_t                e;
    bit                       r1;
    bit                       r2;
    logic [FPR_TAG_WIDTH-1:0] t1;
    logic [FPR_TAG_WIDTH-1:0] t2;
  } m_ent_t;

  m_ent_t    mq[$];
  rs_entry_t sbq[$];
  int        n_checks = 0;
  int        n_err    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic m_ent_t wake(input m_ent_t m);
    m_ent_t r = m;
    if (cdb_valid_in && !r.r1 && r.t1 == cdb_tag_in) begin
      r.r1 = 1'b1;
      r.e.src1_data = cdb_data_in;
    end
    if (cdb_valid_in && !r.r2 && r.t2 == cdb_tag_in) begin
      r.r2 = 1'b1;
      r.e.src2_data = cdb_data_in;
    end
    return r;
  endfunction

  function automatic rs_entry_t rnd_entry(input int rob);
    rs_entry_t e;
    e.op          = fp_op_e'($urandom_range(0, 7));
    e.fmt         = fp_fmt_e'($urandom_range(0, 1));
    e.rm          = 3'($urandom);
    e.src1_data   = {$urandom, $urandom};
    e.src2_data   = {$urandom, $urandom};
    e.rd_phys_tag = FPR_TAG_WIDTH'($urandom);
    e.rob_idx     = ROB_IDX_WIDTH'(rob);
    return e;
  endfunction

  // Called 1 time unit after the inputs of a cycle are driven: compares the
  // cycle's visible outputs with the model, then advances the model to what
  // the next clock edge should produce.
  task automatic evaluate();
    int     k;
    bit     exp_iv;
    bit     accept;
    m_ent_t n;
    #1;
    k = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].r1 && mq[i].r2) begin
        k = i;
        break;
      end
    end
    exp_iv = (k >= 0) && !flush_in;
    accept = disp_valid_in && (mq.size() < DEPTH);
    chk("count_out", longint'(count_out), longint'(mq.size()));
    chk("disp_ready_out", longint'(disp_ready_out), longint'(mq.size() < DEPTH));
    chk("iss_valid_out", longint'(iss_valid_out), longint'(exp_iv));
`ifdef SUPERNOVA_FP_IQ_PERF_EN
    chk("perf_stall_cnt_out", longint'(perf_stall_cnt_out), m_perf);
    if (exp_iv && !iss_ready_in && m_perf < 64'hFFFF_FFFF) m_perf++;
`endif
    if (exp_iv && iss_ready_in) begin
      sbq.push_back(mq[k].e);
      mq.delete(k);
    end
    for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i]);
    if (accept) begin
      n.e  = disp_entry_in;
      n.r1 = disp_src1_rdy_in;
      n.r2 = disp_src2_rdy_in;
      n.t1 = disp_src1_tag_in;
      n.t2 = disp_src2_tag_in;
      mq.push_back(wake(n));
    end
    if (flush_in) mq.delete();
  endtask

  task automatic cyc(
    input bit                       dv,
    input rs_entry_t                e,
    input bit                       r1,
    input bit                       r2,
    input logic [FPR_TAG_WIDTH-1:0] t1,
    input logic [FPR_TAG_WIDTH-1:0] t2,
    input bit                       cv,
    input logic [FPR_TAG_WIDTH-1:0] ct,
    input logic [XLEN-1:0]          cd,
    input bit                       ir,
    input bit                       fl
  );
    @(posedge clk);
    #2;
    disp_valid_in    = dv;
    disp_entry_in    = e;
    disp_src1_rdy_in = r1;
    disp_src2_rdy_in = r2;
    disp_src1_tag_in = t1;
    disp_src2_tag_in = t2;
    cdb_valid_in     = cv;
    cdb_tag_in       = ct;
    cdb_data_in      = cd;
    iss_ready_in     = ir;
    flush_in         = fl;
    evaluate();
  endtask

  task automatic idle(input int n, input bit ir);
    for (int i = 0; i < n; i++) cyc(0, rnd_entry(0), 1, 1, 0, 0, 0, 0, 0, ir, 0);
  endtask

  // Scoreboard monitor: every handshake must match the oldest prediction.
  always @(negedge clk) begin
    rs_entry_t exp_e;
    if (rst_n && iss_valid_out && iss_ready_in) begin
      n_checks++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL issue_unexpected: got rob %0d expected no issue at %0t",
                 iss_entry_out.rob_idx, $time);
      end else begin
        exp_e = sbq.pop_front();
        if (iss_entry_out !== exp_e) begin
          n_err++;
          $display("FAIL issue_entry: got %h expected %h at %0t", iss_entry_out, exp_e, $time);
        end
      end
    end
  end

  localparam logic [XLEN-1:0] ONE_D = 64'h3FF0_0000_0000_0000;

  initial begin
    rst_n            = 1'b0;
    flush_in         = 1'b0;
    disp_valid_in    = 1'b0;
    disp_entry_in    = '0;
    disp_src1_rdy_in = 1'b0;
    disp_src2_rdy_in = 1'b0;
    disp_src1_tag_in = '0;
    disp_src2_tag_in = '0;
    cdb_valid_in     = 1'b0;
    cdb_tag_in       = '0;
    cdb_data_in      = '0;
    iss_ready_in     = 1'b0;
`ifdef SUPERNOVA_FP_IQ_PERF_EN
    m_perf           = 0;
`endif
    #2;
    chk("reset_count", longint'(count_out), 0);
    chk("reset_iss_valid", longint'(iss_valid_out), 0);
    chk("reset_disp_ready", longint'(disp_ready_out), 1);
    #10 rst_n = 1'b1;

    // Single ready dispatch issues the next cycle.
    cyc(1, rnd_entry(1), 1, 1, 0, 0, 0, 0, 0, 1, 0);
    idle(3, 1);

    // A waits on tag 5, B ready: B first, then A with the woken data.
    cyc(1, rnd_entry(2), 0, 1, 5, 0, 0, 0, 0, 1, 0);
    cyc(1, rnd_entry(3), 1, 1, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, rnd_entry(0), 1, 1, 0, 0, 1, 5, ONE_D, 1, 0);
    idle(3, 1);

    // Dispatch-time wakeup on src2 tag 9.
    cyc(1, rnd_entry(4), 1, 0, 0, 9, 1, 9, {$urandom, $urandom}, 1, 0);
    idle(3, 1);

    // Fill to DEPTH, refused 9th dispatch, no credit for same-cycle issue.
    for (int i = 0; i < DEPTH; i++) cyc(1, rnd_entry(10 + i), 1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, rnd_entry(30), 1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, rnd_entry(31), 1, 1, 0, 0, 0, 0, 0, 1, 0);
    idle(DEPTH + 3, 1);

    // Flush together with dispatch and writeback.
    for (int i = 0; i < 5; i++) cyc(1, rnd_entry(40 + i), 1, i[0], 0, 3, 0, 0, 0, 0, 0);
    cyc(1, rnd_entry(50), 1, 1, 0, 0, 1, 3, {$urandom, $urandom}, 1, 1);
    idle(3, 1);

    // Stall cycles on a single ready entry.
    cyc(1, rnd_entry(51), 1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(7, 0);
    idle(3, 1);

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      cyc($urandom_range(0, 9) < 6, rnd_entry(c % 64),
          $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
          FPR_TAG_WIDTH'($urandom_range(0, 7)), FPR_TAG_WIDTH'($urandom_range(0, 7)),
          $urandom_range(0, 1) == 1, FPR_TAG_WIDTH'($urandom_range(0, 7)),
          {$urandom, $urandom},
          $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3);
    end

    // Drain: broadcast every tag so all waiting entries wake and issue.
    for (int c = 0; c < 3 * 64; c++) begin
      cyc(0, rnd_entry(0), 1, 1, 0, 0, 1, FPR_TAG_WIDTH'(c), {$urandom, $urandom}, 1, 0);
    end
    idle(2, 0);
    @(posedge clk);
    #6;
    chk("scoreboard_empty", longint'(sbq.size()), 0);
    chk("final_count", longint'(count_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule : tb_supernova_fp_issue_queue
`default_nettype wire

// File: doc/supernova_fp_issue_queue.md
# supernova_fp_issue_queue

FP reservation station for the Supernova core: the issuing end of the FPU request interface. It buffers renamed F/D instructions from dispatch and snoops the FP writeback bus for source-operand wakeup. It selects the oldest entry whose operands are both ready and hands it to `supernova_fpu_unit` over a valid/ready handshake. It sits between rename/dispatch and the FPU, in the same clock domain.

## Interface
- `DEPTH`, 8: number of entries; power of two, 2..32.
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush_in`  in  1  pipeline flush; drops all entries.
- `disp_valid_in`  in  1  dispatch request.
- `disp_entry_in`  in  `rs_entry_t`  instruction, `src1_data`/`src2_data`, `rd_phys_tag`, `rob_idx`.
- `disp_src1_rdy_in`, `disp_src2_rdy_in`  in  1 each  operand data already valid in `disp_entry_in`.
- `disp_src1_tag_in`, `disp_src2_tag_in`  in  `FPR_TAG_WIDTH` each  producer tags for operands that are not yet ready.
- `disp_ready_out`  out  1  queue can accept a dispatch.
- `cdb_valid_in`  in  1  FP writeback valid; connects to FPU `wb_valid_out`.
- `cdb_tag_in`  in  `FPR_TAG_WIDTH`  writeback FPR tag.
- `cdb_data_in`  in  `XLEN`  writeback data.
- `iss_valid_out`  out  1  issue request to FPU.
- `iss_entry_out`  out  `rs_entry_t`  entry being issued, with captured operand data.
- `iss_ready_in`  in  1  FPU `req_ready_out`.
- `count_out`  out  `$clog2(DEPTH)+1`  occupied entries.

## Operation
- Collapsing age-ordered queue. Slot 0 is always the oldest valid entry. Valid slots are contiguous from slot 0.
- Each slot holds `valid`, the `rs_entry_t` fields, and per operand a ready bit and a tag.
- Dispatch handshake: an entry is accepted when `disp_valid_in && disp_ready_out`.
  - `disp_ready_out = (count < DEPTH)`.
  - No credit is given for a same-cycle issue. A full queue refuses dispatch even if an issue occurs in that cycle.
- Write position: slot `count`, or slot `count-1` if an issue also fires that cycle.
- Wakeup: for each valid slot with an unready operand, a tag match on `cdb_tag_in` while `cdb_valid_in` is high sets the ready bit and captures `cdb_data_in` into that operand's data.
  - Both operands may wake on the same writeback.
- Dispatch-time wakeup: the incoming entry's unready operands are also compared against the CDB in the acceptance cycle. A match is captured, so no wakeup is lost.
- Select: the lowest-index valid slot whose registered ready bits are both 1.
  - `iss_valid_out` is high if such a slot exists and `flush_in` is low.
  - `iss_entry_out` is that slot's contents, driven combinationally from registers.
- Issue fires on `iss_valid_out && iss_ready_in`. The slot is freed and all higher slots shift down by one. Wakeups that cycle apply to the shifted copies.
- `flush_in` clears every valid bit.
  - Flush dominates dispatch, wakeup and issue.
  - `disp_ready_out` is still driven normally during flush, but a dispatch in the flush cycle is discarded.
- Count update per cycle: +1 on dispatch, −1 on issue, net 0 when both fire, 0 on flush.

## Timing
- Reset (async on `rst_n` low): all valid bits 0, count 0. This gives `iss_valid_out=0`, `disp_ready_out=1`, `count_out=0`. `iss_entry_out` is don't-care with `iss_valid_out` low.
- Dispatch with both operands ready, accepted at edge N: `iss_valid_out` can be high in cycle N+1.
- Wakeup at edge N: the woken entry is eligible in cycle N+1. There is no same-cycle CDB-to-issue bypass.
- Issue latency from FPU readiness: zero cycles. The handshake completes in any cycle where both signals are high.
- `iss_valid_out` does not wait for `iss_ready_in`.
- While stalled, the selection may change to an older entry that woke up.
- Simultaneous dispatch + issue + wakeup in one cycle is legal; all three take effect at the same edge.
- Sustained throughput: one issue per cycle when the consumer is always ready.

## Configuration
- `SUPERNOVA_FP_IQ_PERF_EN` defined: adds output `perf_stall_cnt_out` (32 bits, reset 0). It increments every cycle with `iss_valid_out && !iss_ready_in`, saturates at all-ones, and is unaffected by flush.
- Undefined: the port and counter do not exist. All other behaviour is identical.

## Structure
- `supernova_pkg` gets `fp_iq_slot_t`: valid, `rs_entry_t`, src1/src2 ready bits, src1/src2 tags.
- `supernova_pkg` gets the `FP_IQ_DEPTH` default constant.
- One sub-module: `supernova_fp_iq_select`, a combinational oldest-ready priority encoder. Output is the index plus a found bit.

## Test plan
- Reset, then one dispatch with both operands ready and `iss_ready_in=1` -> `iss_valid_out` rises the next cycle; that entry's `rob_idx` appears on `iss_entry_out`; `count_out` goes 1 -> 0.
- Dispatch A (src1 waiting on tag 5) then B (both ready); CDB tag 5 with data 0x3FF0_0000_0000_0000 two cycles later -> B issues first; A issues the cycle after the wakeup carrying src1_data 0x3FF0_0000_0000_0000.
- Dispatch an entry with src2 tag 9 in the same cycle as CDB tag 9 -> operand captured; entry issues the following cycle.
- Fill to `DEPTH=8` with `iss_ready_in=0` -> `disp_ready_out=0` and the 9th dispatch is refused; then one issue -> the count stays 8 that cycle and `disp_ready_out=1` the next cycle.
- Queue holds 5 entries; assert `flush_in` together with a dispatch and a CDB write -> `count_out=0` and `iss_valid_out=0` the next cycle; the dispatched entry is not stored.
- With `SUPERNOVA_FP_IQ_PERF_EN`: hold one ready entry with `iss_ready_in=0` for 7 cycles -> `perf_stall_cnt_out=7`.
